// File: rtl/rx_sched_pkg.sv
// ============================================================================
// Module  : rx_sched_pkg
// Brief   : Shared mode codes, channel ids and FSM state encoding for the
//           RX FIFO scheduler.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package rx_sched_pkg;

  localparam logic [1:0] MODE_09   = 2'b00;
  localparam logic [1:0] MODE_24   = 2'b01;
  localparam logic [1:0] MODE_RR   = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  localparam logic CHAN_09 = 1'b0;
  localparam logic CHAN_24 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PULL = 2'd1,
    ST_WAIT = 2'd2,
    ST_SEND = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rx_fifo_scheduler_if.sv
// ============================================================================
// Module  : rx_fifo_scheduler_if
// Brief   : FIFO read ports and serial byte stream of the RX FIFO scheduler.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface rx_fifo_scheduler_if;

  logic        o_fifo_09_pull;
  logic [31:0] i_fifo_09_data;
  logic        i_fifo_09_empty;
  logic        o_fifo_24_pull;
  logic [31:0] i_fifo_24_data;
  logic        i_fifo_24_empty;
  logic [7:0]  o_byte;
  logic        o_byte_valid;
  logic        i_byte_ready;

  modport master (
    output o_fifo_09_pull, o_fifo_24_pull, o_byte, o_byte_valid,
    input  i_fifo_09_data, i_fifo_09_empty,
    input  i_fifo_24_data, i_fifo_24_empty, i_byte_ready
  );

  modport slave (
    input  o_fifo_09_pull, o_fifo_24_pull, o_byte, o_byte_valid,
    output i_fifo_09_data, i_fifo_09_empty,
    output i_fifo_24_data, i_fifo_24_empty, i_byte_ready
  );

endinterface

`default_nettype wire

// File: rtl/rx_word_serializer.sv
// ============================================================================
// Module  : rx_word_serializer
// Brief   : Loads a 32-bit word and emits it MSB byte first on valid/ready.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module rx_word_serializer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [31:0] word_i,
  input  logic        ready_i,
  output logic [7:0]  byte_o,
  output logic        valid_o,
  output logic        last_o
);

  logic [31:0] sreg_q, sreg_d;
  logic [1:0]  idx_q, idx_d;
  logic        valid_q, valid_d;

  always_comb begin
    sreg_d  = sreg_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (load_i) begin
      sreg_d  = word_i;
      idx_d   = 2'd3;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      if (idx_q == 2'd0) begin
        valid_d = 1'b0;
      end else begin
        sreg_d = {sreg_q[23:0], 8'h00};
        idx_d  = idx_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sreg_q  <= 32'h0;
      idx_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      sreg_q  <= sreg_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign byte_o  = sreg_q[31:24];
  assign valid_o = valid_q;
  assign last_o  = valid_q && ready_i && (idx_q == 2'd0);

endmodule

`default_nettype wire

// File: rtl/rx_fifo_scheduler.sv
// ============================================================================
// Module  : rx_fifo_scheduler
// Brief   : Arbitrates the RX09/RX24 sample FIFOs and serialises each word
//           into a byte stream. Optional macro RX_CHAN_TAG_EN puts the
//           channel id into word bit 31 before serialisation.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module rx_fifo_scheduler
  import rx_sched_pkg::*;
#(
  parameter int FIFO_RD_LAT = 1,
  parameter int CNT_W       = 16
) (
  input  logic                 i_sys_clk,
  input  logic                 i_rst,
  input  logic                 i_enable,
  input  logic [1:0]           i_mode,
  rx_fifo_scheduler_if.master  bus,
  output logic                 o_chan,
  output logic                 o_busy,
  output logic [CNT_W-1:0]     o_cnt_09,
  output logic [CNT_W-1:0]     o_cnt_24
);

  localparam logic [1:0]       c_LAT = 2'(FIFO_RD_LAT);
  localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic               chan_q, chan_d;
  logic               rr_ptr_q, rr_ptr_d;
  logic [1:0]         mode_q, mode_d;
  logic [1:0]         wcnt_q, wcnt_d;
  logic [CNT_W-1:0]   cnt_09_q, cnt_09_d;
  logic [CNT_W-1:0]   cnt_24_q, cnt_24_d;

  logic               ser_load;
  logic               ser_last;
  logic               pull_09;
  logic               pull_24;
  logic [31:0]        word_sel;
  logic [31:0]        word_out;

  always_comb begin
    state_d  = state_q;
    chan_d   = chan_q;
    rr_ptr_d = rr_ptr_q;
    mode_d   = mode_q;
    wcnt_d   = wcnt_q;
    cnt_09_d = cnt_09_q;
    cnt_24_d = cnt_24_q;
    ser_load = 1'b0;
    pull_09  = 1'b0;
    pull_24  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        mode_d = i_mode;
        if (i_enable) begin
          case (i_mode)
            MODE_09: begin
              if (!bus.i_fifo_09_empty) begin
                chan_d  = CHAN_09;
                state_d = ST_PULL;
              end
            end
            MODE_24: begin
              if (!bus.i_fifo_24_empty) begin
                chan_d  = CHAN_24;
                state_d = ST_PULL;
              end
            end
            MODE_RR: begin
              // Pointer channel has priority; fall back to the other one.
              if (rr_ptr_q == CHAN_09) begin
                if (!bus.i_fifo_09_empty) begin
                  chan_d  = CHAN_09;
                  state_d = ST_PULL;
                end else if (!bus.i_fifo_24_empty) begin
                  chan_d  = CHAN_24;
                  state_d = ST_PULL;
                end
              end else begin
                if (!bus.i_fifo_24_empty) begin
                  chan_d  = CHAN_24;
                  state_d = ST_PULL;
                end else if (!bus.i_fifo_09_empty) begin
                  chan_d  = CHAN_09;
                  state_d = ST_PULL;
                end
              end
            end
            default: ;
          endcase
        end
      end
      ST_PULL: begin
        pull_09 = (chan_q == CHAN_09);
        pull_24 = (chan_q == CHAN_24);
        wcnt_d  = 2'd1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (wcnt_q == c_LAT) begin
          ser_load = 1'b1;
          state_d  = ST_SEND;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      ST_SEND: begin
        if (ser_last) begin
          if (chan_q == CHAN_09) cnt_09_d = cnt_09_q + c_ONE;
          else                   cnt_24_d = cnt_24_q + c_ONE;
          if (mode_q == MODE_RR) rr_ptr_d = ~rr_ptr_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      chan_q   <= CHAN_09;
      rr_ptr_q <= CHAN_09;
      mode_q   <= MODE_09;
      wcnt_q   <= 2'd0;
      cnt_09_q <= '0;
      cnt_24_q <= '0;
    end else begin
      state_q  <= state_d;
      chan_q   <= chan_d;
      rr_ptr_q <= rr_ptr_d;
      mode_q   <= mode_d;
      wcnt_q   <= wcnt_d;
      cnt_09_q <= cnt_09_d;
      cnt_24_q <= cnt_24_d;
    end
  end

  assign word_sel = (chan_q == CHAN_24) ? bus.i_fifo_24_data : bus.i_fifo_09_data;

`ifdef RX_CHAN_TAG_EN
  assign word_out = {chan_q, word_sel[30:0]};
`else
  assign word_out = word_sel;
`endif

  rx_word_serializer u_ser (
    .clk_i   (i_sys_clk),
    .rst_i   (i_rst),
    .load_i  (ser_load),
    .word_i  (word_out),
    .ready_i (bus.i_byte_ready),
    .byte_o  (bus.o_byte),
    .valid_o (bus.o_byte_valid),
    .last_o  (ser_last)
  );

  assign bus.o_fifo_09_pull = pull_09;
  assign bus.o_fifo_24_pull = pull_24;
  assign o_chan             = chan_q;
  assign o_busy             = (state_q != ST_IDLE);
  assign o_cnt_09           = cnt_09_q;
  assign o_cnt_24           = cnt_24_q;

endmodule

`default_nettype wire

// File: tb/tb_rx_fifo_scheduler.sv
// ============================================================================
// Module  : tb_rx_fifo_scheduler
// Brief   : Self-checking bench for rx_fifo_scheduler with a word-level model.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rx_fifo_scheduler;

  localparam int CNT_W = 16;

  typedef struct packed {
    logic       c;
    logic [7:0] b;
  } rec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic             chan;
  logic             busy;
  logic [CNT_W-1:0] cnt_09;
  logic [CNT_W-1:0] cnt_24;

  rx_fifo_scheduler_if bus ();

  rx_fifo_scheduler #(.FIFO_RD_LAT(1), .CNT_W(CNT_W)) dut (
    .i_sys_clk (clk),
    .i_rst     (rst),
    .i_enable  (enable),
    .i_mode    (mode),
    .bus       (bus.master),
    .o_chan    (chan),
    .o_busy    (busy),
    .o_cnt_09  (cnt_09),
    .o_cnt_24  (cnt_24)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] q09[$];
  logic [31:0] q24[$];
  rec_t        got[$];
  rec_t        exp[$];
  int          pulls09 = 0, pulls24 = 0, both_pulls = 0, pull_empty = 0;
  int          rdy_mode = 0;
  int          rdy_step = 0;
  logic        exp_ptr = 1'b0;
  int          exp_cnt09 = 0, exp_cnt24 = 0;
  int          exp_n09 = 0, exp_n24 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // FIFO read model with one cycle of read latency.
  always @(posedge clk) begin
    if (bus.o_fifo_09_pull) begin
      if (q09.size() > 0) bus.i_fifo_09_data <= q09.pop_front();
      else pull_empty++;
    end
    if (bus.o_fifo_24_pull) begin
      if (q24.size() > 0) bus.i_fifo_24_data <= q24.pop_front();
      else pull_empty++;
    end
  end

  always @(negedge clk) begin
    bus.i_fifo_09_empty = (q09.size() == 0);
    bus.i_fifo_24_empty = (q24.size() == 0);
  end

  logic [3:0] rdy_pat = 4'b1001;
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1)      bus.i_byte_ready = 1'($urandom_range(0, 1));
    else if (rdy_mode == 2) begin
      bus.i_byte_ready = rdy_pat[3 - (rdy_step % 4)];
      rdy_step++;
    end
    else                    bus.i_byte_ready = 1'b1;
  end

  logic hold_prev = 1'b0;
  rec_t hold_rec;
  always @(negedge clk) begin
    if (!rst) begin
      if (hold_prev) begin
        check("hold_valid", {31'd0, bus.o_byte_valid}, 32'd1);
        check("hold_byte", {23'd0, chan, bus.o_byte}, {23'd0, hold_rec});
      end
      if (bus.o_byte_valid && bus.i_byte_ready) got.push_back({chan, bus.o_byte});
      hold_prev = bus.o_byte_valid && !bus.i_byte_ready;
      hold_rec  = {chan, bus.o_byte};
      if (bus.o_fifo_09_pull) pulls09++;
      if (bus.o_fifo_24_pull) pulls24++;
      if (bus.o_fifo_09_pull && bus.o_fifo_24_pull) both_pulls++;
    end else begin
      hold_prev = 1'b0;
    end
  end

  // Word-level arbitration model: all words are queued before enabling.
  task automatic build_exp(input logic [1:0] m);
    logic [31:0] a[$];
    logic [31:0] b[$];
    logic [31:0] w;
    logic        c;
    logic        found;
    a = q09; b = q24;
    exp.delete(); exp_n09 = 0; exp_n24 = 0;
    forever begin
      found = 1'b0; c = 1'b0;
      if (m == 2'b00 && a.size() > 0) begin found = 1'b1; c = 1'b0; end
      if (m == 2'b01 && b.size() > 0) begin found = 1'b1; c = 1'b1; end
      if (m == 2'b10) begin
        if (!exp_ptr) begin
          if (a.size() > 0)      begin found = 1'b1; c = 1'b0; end
          else if (b.size() > 0) begin found = 1'b1; c = 1'b1; end
        end else begin
          if (b.size() > 0)      begin found = 1'b1; c = 1'b1; end
          else if (a.size() > 0) begin found = 1'b1; c = 1'b0; end
        end
      end
      if (!found) break;
      w = c ? b.pop_front() : a.pop_front();
`ifdef RX_CHAN_TAG_EN
      w[31] = c;
`endif
      for (int k = 3; k >= 0; k--) exp.push_back({c, w[k*8 +: 8]});
      if (c) exp_n24++; else exp_n09++;
      if (m == 2'b10) exp_ptr = ~exp_ptr;
    end
  endtask

  task automatic wait_done(input int n, input string tag);
    int t;
    repeat (20) @(negedge clk);
    t = 0;
    while (!(got.size() >= n && !busy) && t < 4000) begin
      @(negedge clk); #1;
      t++;
    end
    if (t >= 4000) check({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic run(input logic [1:0] m, input string tag);
    int p09, p24, n;
    build_exp(m);
    got.delete();
    p09 = pulls09; p24 = pulls24;
    @(negedge clk);
    mode = m; enable = 1'b1;
    wait_done(exp.size(), tag);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    exp_cnt09 += exp_n09; exp_cnt24 += exp_n24;
    check({tag, "_nbytes"}, got.size(), exp.size());
    n = (got.size() < exp.size()) ? got.size() : exp.size();
    for (int i = 0; i < n; i++) check({tag, "_byte"}, {23'd0, got[i]}, {23'd0, exp[i]});
    check({tag, "_cnt09"}, {16'd0, cnt_09}, exp_cnt09);
    check({tag, "_cnt24"}, {16'd0, cnt_24}, exp_cnt24);
    check({tag, "_pulls09"}, pulls09 - p09, exp_n09);
    check({tag, "_pulls24"}, pulls24 - p24, exp_n24);
    check({tag, "_both_pulls"}, both_pulls, 0);
    check({tag, "_pull_empty"}, pull_empty, 0);
    q09.delete(); q24.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [7:0] first_exp;
    bus.i_fifo_09_data = 32'h0;
    bus.i_fifo_24_data = 32'h0;
    bus.i_byte_ready   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, bus.o_byte_valid}, 32'd0);
    check("rst_byte",  {24'd0, bus.o_byte}, 32'd0);
    check("rst_chan",  {31'd0, chan}, 32'd0);
    check("rst_pulls", {30'd0, bus.o_fifo_09_pull, bus.o_fifo_24_pull}, 32'd0);
    check("rst_cnt",   {cnt_09, cnt_24}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset asserted mid-word, right after the second byte handshake.
    q09.push_back(32'h3CADBEEF);
    q09.push_back(32'h01020304);
    repeat (2) @(negedge clk);
    mode = 2'b00; enable = 1'b1;
    for (int t = 0; t < 200 && got.size() < 2; t++) begin
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, bus.o_byte_valid}, 32'd0);
    check("mid_rst_busy",  {31'd0, busy}, 32'd0);
    check("mid_rst_byte",  {24'd0, bus.o_byte}, 32'd0);
    check("mid_rst_cnt",   {cnt_09, cnt_24}, 32'd0);
    check("mid_rst_nbytes", got.size(), 2);
    if (got.size() >= 2) begin
      check("mid_rst_b0", {23'd0, got[0]}, {23'd0, 1'b0, 8'h3C});
      check("mid_rst_b1", {23'd0, got[1]}, {23'd0, 1'b0, 8'hAD});
    end
    enable = 1'b0;
    exp_ptr = 1'b0; exp_cnt09 = 0; exp_cnt24 = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run(2'b00, "after_rst");

    // Single-channel 09 with a word parked in 24 that must not be pulled.
    q09.push_back(32'h11223344);
    q24.push_back(32'hCAFE0001);
    repeat (2) @(negedge clk);
    run(2'b00, "mode09");

    // Round-robin with both channels loaded.
    for (int i = 0; i < 3; i++) begin
      q09.push_back({8'hA0 + 8'(i), 24'($urandom)});
      q24.push_back({8'hB0 + 8'(i), 24'($urandom)});
    end
    repeat (2) @(negedge clk);
    run(2'b10, "rr_both");

    // Round-robin with 24 empty.
    q09.push_back($urandom);
    q09.push_back($urandom);
    repeat (2) @(negedge clk);
    run(2'b10, "rr_09only");

    // Ready pattern 1,0,0,1 repeating.
    rdy_mode = 2;
    q24.push_back($urandom);
    q09.push_back($urandom);
    repeat (2) @(negedge clk);
    run(2'b10, "rdy_pat");

    // Channel tag boundary word.
    rdy_mode = 0;
    q24.push_back(32'h7FFFFFFF);
    repeat (2) @(negedge clk);
`ifdef RX_CHAN_TAG_EN
    first_exp = 8'hFF;
`else
    first_exp = 8'h7F;
`endif
    run(2'b01, "tag");
    if (got.size() > 0) check("tag_first", {24'd0, got[0].b}, {24'd0, first_exp});
    else check("tag_first_missing", 32'd0, 32'd1);

    // Hold mode must never schedule.
    q09.push_back($urandom);
    q24.push_back($urandom);
    repeat (2) @(negedge clk);
    run(2'b11, "hold");

    // Randomised modes, occupancies and back-pressure.
    rdy_mode = 1;
    for (int r = 0; r < 6; r++) begin
      int n9, n24;
      logic [1:0] m;
      n9 = $urandom_range(0, 4);
      n24 = $urandom_range(0, 4);
      m = 2'($urandom_range(0, 2));
      for (int i = 0; i < n9; i++) q09.push_back($urandom);
      for (int i = 0; i < n24; i++) q24.push_back($urandom);
      repeat (2) @(negedge clk);
      run(m, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
